// File: rtl/wav_prefetch.sv
// Byte prefetch buffer: walks a DDRAM byte range with one read in flight and feeds a FWFT FIFO.
// Optional underrun counter port enabled by defining WAV_PREFETCH_UNDERRUN_EN.
module wav_prefetch #(
  parameter int unsigned ADDR_W     = 28,
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stop,
  input  logic [ADDR_W-1:0]     start_addr,
  input  logic [ADDR_W-1:0]     end_addr,
  input  logic                  loop,
  input  logic                  hold,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic                  mem_rd,
  input  logic                  mem_ready,
  input  logic [7:0]            mem_data,
  input  logic                  snd_req,
  output logic [7:0]            snd_data,
  output logic                  snd_valid,
  output logic                  active,
  output logic                  done,
  output logic [DEPTH_LOG2:0]   level
`ifdef WAV_PREFETCH_UNDERRUN_EN
  ,
  output logic [7:0]            underrun_cnt
`endif
);

  localparam int unsigned Depth = 2 ** DEPTH_LOG2;

  typedef enum logic [1:0] {StIdle, StIssue, StSettle, StWait} state_e;

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     fetch_ptr_q, fetch_ptr_d;
  logic [ADDR_W-1:0]     range_start_q, range_start_d;
  logic [ADDR_W-1:0]     range_end_q, range_end_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic                  loop_q, loop_d;
  logic                  active_q, active_d;
  logic                  finished_q, finished_d;
  logic                  discard_q, discard_d;
  logic                  done_q, done_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [7:0]            fifo_q [Depth];

  logic in_flight, complete, do_push, do_pop, can_issue;

  assign in_flight = (state_q != StIdle);
  assign complete  = (state_q == StWait) & mem_ready;
  // A start or stop in the completion cycle flushes, so the returning byte is dropped too.
  assign do_push   = complete & ~discard_q & ~start & ~stop;
  assign do_pop    = snd_req & (count_q != '0) & ~start & ~stop;
  // Nothing is in flight in StIdle, so the space check reduces to "FIFO not full".
  assign can_issue = active_q & ~finished_q & ~hold & ~count_q[DEPTH_LOG2] & ~start & ~stop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      fetch_ptr_q   <= '0;
      range_start_q <= '0;
      range_end_q   <= '0;
      mem_addr_q    <= '0;
      loop_q        <= 1'b0;
      active_q      <= 1'b0;
      finished_q    <= 1'b0;
      discard_q     <= 1'b0;
      done_q        <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      for (int i = 0; i < Depth; i++) fifo_q[i] <= 8'h00;
    end else begin
      state_q       <= state_d;
      fetch_ptr_q   <= fetch_ptr_d;
      range_start_q <= range_start_d;
      range_end_q   <= range_end_d;
      mem_addr_q    <= mem_addr_d;
      loop_q        <= loop_d;
      active_q      <= active_d;
      finished_q    <= finished_d;
      discard_q     <= discard_d;
      done_q        <= done_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      if (do_push) fifo_q[wr_ptr_q] <= mem_data;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (can_issue) state_d = StIssue;
      StIssue:  state_d = StSettle;
      StSettle: state_d = StWait;
      StWait:   if (mem_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    fetch_ptr_d   = fetch_ptr_q;
    range_start_d = range_start_q;
    range_end_d   = range_end_q;
    mem_addr_d    = mem_addr_q;
    loop_d        = loop_q;
    active_d      = active_q;
    finished_d    = finished_q;
    discard_d     = discard_q;
    done_d        = 1'b0;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;

    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;

    if ((state_q == StIdle) && can_issue) mem_addr_d = fetch_ptr_q;

    if (complete) begin
      discard_d = 1'b0;
      // Discarded bytes belong to an old range; the pointer already holds the new start.
      if (do_push) begin
        if (fetch_ptr_q == range_end_q) begin
          if (loop_q) fetch_ptr_d = range_start_q;
          else        finished_d  = 1'b1;
        end else begin
          fetch_ptr_d = fetch_ptr_q + ADDR_W'(1);
        end
      end
    end

    if (active_q && finished_q && (count_d == '0)) begin
      active_d = 1'b0;
      done_d   = 1'b1;
    end

    if (stop || start) begin
      rd_ptr_d  = wr_ptr_q;
      count_d   = '0;
      discard_d = in_flight & ~complete;
      done_d    = 1'b0;
      active_d  = 1'b0;
    end

    if (start && !stop) begin
      range_start_d = start_addr;
      range_end_d   = end_addr;
      loop_d        = loop;
      fetch_ptr_d   = start_addr;
      finished_d    = 1'b0;
      if (end_addr < start_addr) done_d   = 1'b1;
      else                       active_d = 1'b1;
    end
  end

  always_comb begin
    mem_rd = (state_q == StIssue);
  end

  assign mem_addr  = mem_addr_q;
  assign snd_data  = fifo_q[rd_ptr_q];
  assign snd_valid = (count_q != '0);
  assign active    = active_q;
  assign done      = done_q;
  assign level     = count_q;

`ifdef WAV_PREFETCH_UNDERRUN_EN
  logic [7:0] underrun_q, underrun_d;

  always_comb begin
    underrun_d = underrun_q;
    if (start) begin
      underrun_d = 8'h00;
    end else if (snd_req && (count_q == '0) && active_q && (underrun_q != 8'hFF)) begin
      underrun_d = underrun_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) underrun_q <= 8'h00;
    else       underrun_q <= underrun_d;
  end

  assign underrun_cnt = underrun_q;
`endif

endmodule

// File: tb/tb_wav_prefetch.sv
// Self-checking bench for wav_prefetch: scenario table plus directed multi-cycle sequences.
// Define WAV_PREFETCH_UNDERRUN_EN to also exercise the underrun counter.
module tb_wav_prefetch;

  localparam int AW = 28;
  localparam int LAT = 5;

  logic          clk = 1'b0;
  logic          reset, start, stop, loop, hold, mem_rd, mem_ready, snd_req;
  logic [AW-1:0] start_addr, end_addr, mem_addr;
  logic [7:0]    mem_data, snd_data;
  logic          snd_valid, active, done;
  logic [4:0]    level;
`ifdef WAV_PREFETCH_UNDERRUN_EN
  logic [7:0]    underrun_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int addr_err = 0;
  logic [AW-1:0] addr_log[$];

  always #5 clk = ~clk;

  wav_prefetch #(.ADDR_W(AW), .DEPTH_LOG2(4)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .start_addr(start_addr), .end_addr(end_addr), .loop(loop), .hold(hold),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_ready(mem_ready), .mem_data(mem_data),
    .snd_req(snd_req), .snd_data(snd_data), .snd_valid(snd_valid),
    .active(active), .done(done), .level(level)
`ifdef WAV_PREFETCH_UNDERRUN_EN
    , .underrun_cnt(underrun_cnt)
`endif
  );

  // DDRAM model: ready drops after a read pulse, returns addr[7:0] LAT cycles later.
  logic          busy;
  int            lat_cnt;
  logic [AW-1:0] cur_addr;
  always @(posedge clk) begin
    if (reset) begin
      mem_ready <= 1'b1;
      mem_data  <= 8'h00;
      busy      <= 1'b0;
    end else if (mem_rd) begin
      addr_log.push_back(mem_addr);
      mem_ready <= 1'b0;
      busy      <= 1'b1;
      lat_cnt   <= LAT;
      cur_addr  <= mem_addr;
    end else if (busy) begin
      if (mem_addr !== cur_addr) addr_err <= addr_err + 1;
      if (lat_cnt <= 1) begin
        mem_ready <= 1'b1;
        mem_data  <= cur_addr[7:0];
        busy      <= 1'b0;
      end else begin
        lat_cnt <= lat_cnt - 1;
      end
    end
  end

  always @(posedge clk) if (!reset && done) done_cnt <= done_cnt + 1;

  typedef struct {
    logic [AW-1:0] sa;
    logic [AW-1:0] ea;
    logic          lp;
    int            npop;
    logic [63:0]   exp;   // byte i at [8*i +: 8]
    logic          exp_done;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_start(input logic [AW-1:0] sa, input logic [AW-1:0] ea, input logic lp);
    start_addr = sa; end_addr = ea; loop = lp; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic pop(output logic [7:0] d, output bit ok);
    int t = 0;
    ok = 1'b0;
    d = 8'h00;
    while (!snd_valid && t < 200) begin @(negedge clk); t++; end
    if (snd_valid) begin
      ok = 1'b1;
      d = snd_data;
      snd_req = 1'b1;
      @(negedge clk);
      snd_req = 1'b0;
    end
  endtask

  task automatic wait_rd(output bit ok);
    int t = 0;
    while (!mem_rd && t < 100) begin @(negedge clk); t++; end
    ok = mem_rd;
  endtask

  initial begin
    logic [7:0] d;
    bit ok;
    int base, dbase;

    vecs[0] = '{sa: 'h100, ea: 'h103, lp: 1'b0, npop: 4, exp: 64'h03020100, exp_done: 1'b1};
    vecs[1] = '{sa: 'h010, ea: 'h012, lp: 1'b1, npop: 8, exp: 64'h11101211_10121110,
                exp_done: 1'b0};
    vecs[2] = '{sa: 'h2FE, ea: 'h301, lp: 1'b0, npop: 4, exp: 64'h0100FFFE, exp_done: 1'b1};
    vecs[3] = '{sa: 'h055, ea: 'h055, lp: 1'b0, npop: 1, exp: 64'h55, exp_done: 1'b1};
    vecs[4] = '{sa: 'h007, ea: 'h007, lp: 1'b1, npop: 3, exp: 64'h070707, exp_done: 1'b0};

    reset = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0; hold = 1'b0; snd_req = 1'b0;
    start_addr = '0; end_addr = '0;
    cycles(3);
    reset = 1'b0;
    @(negedge clk);
    check("rst_valid", snd_valid, 0);
    check("rst_active", active, 0);
    check("rst_level", level, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_done", done, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_snd_data", snd_data, 0);

    snd_req = 1'b1;
    @(negedge clk);
    snd_req = 1'b0;
    check("idle_pop_level", level, 0);
    check("idle_pop_valid", snd_valid, 0);

    for (int v = 0; v < 5; v++) begin
      do_stop();
      cycles(15);
      base  = addr_log.size();
      dbase = done_cnt;
      do_start(vecs[v].sa, vecs[v].ea, vecs[v].lp);
      for (int i = 0; i < vecs[v].npop; i++) begin
        pop(d, ok);
        check($sformatf("v%0d_pop%0d_ok", v, i), ok, 1);
        check($sformatf("v%0d_pop%0d_data", v, i), d, vecs[v].exp[8*i +: 8]);
        check($sformatf("v%0d_rd%0d_addr", v, i), addr_log[base+i][7:0], vecs[v].exp[8*i +: 8]);
      end
      if (vecs[v].exp_done) begin
        cycles(3);
        check($sformatf("v%0d_done", v), done_cnt - dbase, 1);
        check($sformatf("v%0d_inactive", v), active, 0);
        check($sformatf("v%0d_reads", v), addr_log.size() - base,
              vecs[v].ea - vecs[v].sa + 1);
      end else begin
        cycles(30);
        check($sformatf("v%0d_no_done", v), done_cnt - dbase, 0);
        check($sformatf("v%0d_active", v), active, 1);
      end
    end

    do_stop();
    @(negedge clk);
    check("stop_level", level, 0);
    check("stop_active", active, 0);
    cycles(15);

    // Empty range: done next cycle, no reads
    base  = addr_log.size();
    dbase = done_cnt;
    do_start('h50, 'h40, 1'b0);
    check("empty_done", done, 1);
    check("empty_active", active, 0);
    @(negedge clk);
    check("empty_done_pulse", done, 0);
    cycles(10);
    check("empty_reads", addr_log.size() - base, 0);
    check("empty_done_cnt", done_cnt - dbase, 1);

    // Back-pressure
    base = addr_log.size();
    do_start('h0, 'h3F, 1'b0);
    cycles(300);
    check("bp_level", level, 16);
    check("bp_reads", addr_log.size() - base, 16);
    pop(d, ok);
    check("bp_pop_data", d, 8'h00);
    cycles(40);
    check("bp_reads_after_pop", addr_log.size() - base, 17);
    check("bp_level_after_pop", level, 16);
    do_stop();
    cycles(15);

    // Hold during WAIT
    base = addr_log.size();
    do_start('h20, 'h2F, 1'b0);
    wait_rd(ok);
    check("hold_first_rd", ok, 1);
    cycles(2);
    hold = 1'b1;
    cycles(40);
    check("hold_reads", addr_log.size() - base, 1);
    check("hold_level", level, 1);
    check("hold_data", snd_data, 8'h20);
    hold = 1'b0;
    cycles(40);
    check("hold_release", (addr_log.size() - base) > 1, 1);
    do_stop();
    cycles(15);

    // Restart while read of 0x105 pending
    base  = addr_log.size();
    do_start('h105, 'h10F, 1'b0);
    wait_rd(ok);
    check("rs_rd", ok, 1);
    check("rs_addr", mem_addr, 'h105);
    @(negedge clk);
    dbase = done_cnt;
    do_start('h200, 'h203, 1'b0);
    for (int i = 0; i < 4; i++) begin
      pop(d, ok);
      check($sformatf("rs_pop%0d", i), d, i);
    end
    check("rs_next_addr", addr_log[base+1], 'h200);
    cycles(3);
    check("rs_done", done_cnt - dbase, 1);
    check("rs_inactive", active, 0);

`ifdef WAV_PREFETCH_UNDERRUN_EN
    hold = 1'b1;
    do_start('h300, 'h3FF, 1'b0);
    cycles(2);
    d = snd_data;
    for (int i = 0; i < 3; i++) begin
      snd_req = 1'b1;
      @(negedge clk);
      snd_req = 1'b0;
      @(negedge clk);
    end
    check("ur_cnt", underrun_cnt, 3);
    check("ur_data", snd_data, d);
    check("ur_level", level, 0);
    do_start('h300, 'h3FF, 1'b0);
    check("ur_clear", underrun_cnt, 0);
    hold = 1'b0;
    do_stop();
    cycles(15);
`endif

    check("addr_stable", addr_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
